mem_access_unit: RTL and testbench

// Parametrised memory-stage access engine for the Y86 pipeline. Takes one

---
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access engine: splits one DATA_W-bit load/store into BUS_W-bit
// bus beats with byte enables, handling misalignment and word-address wrap.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int BUS_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              req_valid,
  input  logic                              req_write,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [DATA_W-1:0]                 req_wdata,
  output logic                              req_ready,
  output logic                              stall,
  output logic                              resp_valid,
  output logic [DATA_W-1:0]                 resp_rdata,
  output logic [ADDR_W-$clog2(BUS_W/8)-1:0] bus_addr,
  output logic                              bus_read,
  output logic                              bus_write,
  output logic [BUS_W/8-1:0]                bus_be,
  output logic [BUS_W-1:0]                  bus_wdata,
  input  logic [BUS_W-1:0]                  bus_rdata,
  input  logic                              bus_wait
);

  localparam int LANES      = BUS_W / 8;
  localparam int OFFS_W     = $clog2(LANES);
  localparam int WADDR_W    = ADDR_W - OFFS_W;
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int MAX_BEATS  = DATA_W / BUS_W + 1;
  localparam int BEAT_W     = $clog2(MAX_BEATS + 1);
  localparam int OFF_REG_W  = (OFFS_W > 0) ? OFFS_W : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  stateT               state;
  stateT               nextState;
  logic [WADDR_W-1:0]  wordAddrReg;
  logic [OFF_REG_W-1:0] offReg;
  logic [OFF_REG_W-1:0] reqOff;
  logic                writeReg;
  logic [DATA_W-1:0]   wdataReg;
  logic [DATA_W-1:0]   rdataAcc;
  logic [DATA_W-1:0]   rdataNext;
  logic [DATA_W-1:0]   respRdata;
  logic [BEAT_W-1:0]   beatIdx;
  logic [BEAT_W-1:0]   numBeats;
  logic [BEAT_W-1:0]   reqBeats;
  logic                accept;
  logic                beatDone;
  logic                lastBeat;
  logic [LANES-1:0]    beBeat;
  logic [BUS_W-1:0]    wdataBeat;
  int                  byteIdx;

  generate
    if (OFFS_W > 0) begin : genOff
      assign reqOff = req_addr[OFF_REG_W-1:0];
    end else begin : genNoOff
      assign reqOff = '0;
    end
  endgenerate

  // Beats needed to cover the word once it is shifted up by its lane offset
  assign reqBeats   = BEAT_W'((int'(reqOff) + DATA_BYTES + LANES - 1) / LANES);
  assign accept     = (state == IDLE) && req_valid;
  assign beatDone   = (state == ACCESS) && !bus_wait;
  assign lastBeat   = (beatIdx == numBeats - BEAT_W'(1));
  assign resp_rdata = respRdata;

  // Map each lane of the current beat back to a byte of the request word
  always_comb begin
    beBeat    = '0;
    wdataBeat = '0;
    rdataNext = rdataAcc;
    byteIdx   = 0;
    for (int j = 0; j < LANES; j++) begin
      byteIdx = int'(beatIdx) * LANES + j - int'(offReg);
      if (byteIdx >= 0 && byteIdx < DATA_BYTES) begin
        beBeat[j]                  = 1'b1;
        wdataBeat[j*8 +: 8]        = wdataReg[byteIdx*8 +: 8];
        rdataNext[byteIdx*8 +: 8]  = bus_rdata[j*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    req_ready  = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    bus_read   = 1'b0;
    bus_write  = 1'b0;
    bus_be     = '0;
    bus_wdata  = '0;
    bus_addr   = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          nextState = ACCESS;
        end
      end
      ACCESS: begin
        stall     = 1'b1;
        bus_read  = !writeReg;
        bus_write = writeReg;
        bus_be    = beBeat;
        bus_addr  = wordAddrReg + WADDR_W'(beatIdx);
        if (writeReg) begin
          bus_wdata = wdataBeat;
        end
        if (!bus_wait && lastBeat) begin
          nextState = DONE;
        end
      end
      DONE: begin
        stall      = 1'b1;
        resp_valid = 1'b1;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request latch, beat counter and load-data assembly
  always_ff @(posedge clock) begin
    if (reset) begin
      wordAddrReg <= '0;
      offReg      <= '0;
      writeReg    <= 1'b0;
      wdataReg    <= '0;
      beatIdx     <= '0;
      numBeats    <= '0;
      rdataAcc    <= '0;
      respRdata   <= '0;
    end else if (accept) begin
      wordAddrReg <= req_addr[ADDR_W-1:OFFS_W];
      offReg      <= reqOff;
      writeReg    <= req_write;
      wdataReg    <= req_wdata;
      beatIdx     <= '0;
      numBeats    <= reqBeats;
      rdataAcc    <= '0;
    end else if (beatDone) begin
      beatIdx <= beatIdx + BEAT_W'(1);
      if (!writeReg) begin
        rdataAcc <= rdataNext;
        if (lastBeat) begin
          respRdata <= rdataNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: byte-addressed reference memory model
// predicts every bus beat, the response latency and the assembled load data.
module tb_mem_access_unit;

  localparam int NBYTES = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [30:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_wait;

  logic        wReqValid;
  logic        wReqWrite;
  logic [31:0] wReqAddr;
  logic [31:0] wReqWdata;
  logic        wReqReady;
  logic        wStall;
  logic        wRespValid;
  logic [31:0] wRespRdata;
  logic [29:0] wBusAddr;
  logic        wBusRead;
  logic        wBusWrite;
  logic [3:0]  wBusBe;
  logic [31:0] wBusWdata;
  logic [31:0] wBusRdata;
  logic        wBusWait;

  logic [7:0]  physMem  [logic [31:0]];
  logic [7:0]  modelMem [logic [31:0]];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] lastLoad = '0;

  always #5 clock = ~clock;

  mem_access_unit #(.DATA_W(32), .BUS_W(16), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_wait(bus_wait)
  );

  mem_access_unit #(.DATA_W(32), .BUS_W(32), .ADDR_W(32)) dutWide (
    .clock(clock), .reset(reset),
    .req_valid(wReqValid), .req_write(wReqWrite), .req_addr(wReqAddr), .req_wdata(wReqWdata),
    .req_ready(wReqReady), .stall(wStall), .resp_valid(wRespValid), .resp_rdata(wRespRdata),
    .bus_addr(wBusAddr), .bus_read(wBusRead), .bus_write(wBusWrite), .bus_be(wBusBe),
    .bus_wdata(wBusWdata), .bus_rdata(wBusRdata), .bus_wait(wBusWait)
  );

  function automatic logic [7:0] physByte(input logic [31:0] a);
    return physMem.exists(a) ? physMem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] modelByte(input logic [31:0] a);
    return modelMem.exists(a) ? modelMem[a] : 8'h00;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete request; abortBeat >= 0 fires reset during that beat instead
  task automatic applyStimulus(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                               input bit randWait, input int waitBeat, input int waitLen,
                               input int abortBeat);
    logic [30:0] expAddr [8];
    logic [1:0]  expBe   [8];
    logic [15:0] expWd   [8];
    logic [31:0] expRdata;
    logic [31:0] a;
    logic [31:0] rd;
    logic [47:0] physWin;
    logic [47:0] modelWin;
    int          nb;
    int          k;
    int          cyc;
    int          waits;
    int          beatWaits;
    bit          w;
    bit          newBeat;
    bit          finished;
    bit          aborted;

    nb = 0;
    expRdata = '0;
    for (int i = 0; i < 8; i++) begin
      expAddr[i] = '0;
      expBe[i]   = '0;
      expWd[i]   = '0;
    end
    for (int i = 0; i < NBYTES; i++) begin
      a = addr + 32'(i);
      if (nb == 0) newBeat = 1'b1;
      else         newBeat = (a[31:1] != expAddr[nb-1]);
      if (newBeat) begin
        expAddr[nb] = a[31:1];
        nb++;
      end
      expBe[nb-1][a[0]] = 1'b1;
      expWd[nb-1][int'(a[0])*8 +: 8] = wdata[i*8 +: 8];
      expRdata[i*8 +: 8] = modelByte(a);
    end

    @(negedge clock);
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    bus_wait  = 1'b0;
    bus_rdata = 16'($urandom);
    #1;
    checkOutput("accept_ready", req_ready, 1'b1);
    checkOutput("accept_stall", stall, 1'b1);

    k = 0; cyc = 0; waits = 0; beatWaits = 0; finished = 1'b0; aborted = 1'b0;
    for (int guard = 0; guard < 200 && !finished && !aborted; guard++) begin
      @(negedge clock);
      cyc++;
      if (k == abortBeat) begin
        reset     = 1'b1;
        req_valid = 1'b0;
        bus_wait  = 1'b0;
        aborted   = 1'b1;
      end else if (k < nb) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        w = randWait ? ($urandom_range(0, 3) == 0) : (k == waitBeat && beatWaits < waitLen);
        bus_wait = w;
        rd = $urandom;
        for (int j = 0; j < 2; j++) begin
          if (bus_be[j]) rd[j*8 +: 8] = physByte((32'(bus_addr) << 1) + 32'(j));
        end
        bus_rdata = rd[15:0];
        #1;
        checkOutput("beat_addr", 64'(bus_addr), 64'(expAddr[k]));
        checkOutput("beat_be", 64'(bus_be), 64'(expBe[k]));
        checkOutput("beat_read", bus_read, !write);
        checkOutput("beat_write", bus_write, write);
        if (write) checkOutput("beat_wdata", 64'(bus_wdata), 64'(expWd[k]));
        checkOutput("beat_resp_valid", resp_valid, 1'b0);
        checkOutput("beat_ready", req_ready, 1'b0);
        checkOutput("beat_stall", stall, 1'b1);
        if (!w) begin
          if (bus_write) begin
            for (int j = 0; j < 2; j++) begin
              if (bus_be[j]) physMem[(32'(bus_addr) << 1) + 32'(j)] = bus_wdata[j*8 +: 8];
            end
          end
          k++;
          beatWaits = 0;
        end else begin
          waits++;
          beatWaits++;
        end
      end else begin
        req_valid = 1'b0;
        #1;
        checkOutput("done_resp_valid", resp_valid, 1'b1);
        checkOutput("done_latency", 64'(cyc), 64'(nb + 1 + waits));
        checkOutput("done_bus_read", bus_read, 1'b0);
        checkOutput("done_bus_write", bus_write, 1'b0);
        checkOutput("done_bus_be", 64'(bus_be), 64'h0);
        checkOutput("done_stall", stall, 1'b1);
        checkOutput("done_ready", req_ready, 1'b0);
        checkOutput("done_rdata", resp_rdata, write ? lastLoad : expRdata);
        finished = 1'b1;
      end
    end
    if (!aborted) checkOutput("txn_complete", finished, 1'b1);

    if (aborted) begin
      @(negedge clock);
      #1;
      checkOutput("abort_bus_read", bus_read, 1'b0);
      checkOutput("abort_bus_write", bus_write, 1'b0);
      checkOutput("abort_bus_be", 64'(bus_be), 64'h0);
      checkOutput("abort_bus_addr", 64'(bus_addr), 64'h0);
      checkOutput("abort_bus_wdata", 64'(bus_wdata), 64'h0);
      checkOutput("abort_resp_valid", resp_valid, 1'b0);
      checkOutput("abort_ready", req_ready, 1'b1);
      checkOutput("abort_rdata", resp_rdata, 32'h0);
      reset = 1'b0;
      @(negedge clock);
      #1;
      checkOutput("abort_no_resp", resp_valid, 1'b0);
      checkOutput("abort_idle", req_ready, 1'b1);
      checkOutput("abort_bus_quiet", bus_write, 1'b0);
      for (int i = 0; i < NBYTES; i++) modelMem[addr + 32'(i)] = physByte(addr + 32'(i));
      lastLoad = '0;
    end else begin
      if (write) begin
        for (int i = 0; i < NBYTES; i++) modelMem[addr + 32'(i)] = wdata[i*8 +: 8];
      end else begin
        lastLoad = expRdata;
      end
      @(negedge clock);
      #1;
      checkOutput("after_ready", req_ready, 1'b1);
      checkOutput("after_resp_valid", resp_valid, 1'b0);
      checkOutput("after_stall", stall, 1'b0);
      checkOutput("after_bus_idle", {bus_read, bus_write}, 2'b00);
      if (write) begin
        // Window includes one byte either side to catch stray lane writes
        for (int i = 0; i < 6; i++) begin
          physWin[i*8 +: 8]  = physByte(addr - 32'd1 + 32'(i));
          modelWin[i*8 +: 8] = modelByte(addr - 32'd1 + 32'(i));
        end
        checkOutput("store_mem", physWin, modelWin);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    bus_rdata = '0; bus_wait = 1'b0;
    wReqValid = 1'b0; wReqWrite = 1'b0; wReqAddr = '0; wReqWdata = '0;
    wBusRdata = '0; wBusWait = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checkOutput("rst_ready", req_ready, 1'b1);
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_bus_rw", {bus_read, bus_write}, 2'b00);
    checkOutput("rst_bus_be", 64'(bus_be), 64'h0);
    checkOutput("rst_bus_addr", 64'(bus_addr), 64'h0);
    checkOutput("rst_bus_wdata", 64'(bus_wdata), 64'h0);
    checkOutput("rst_rdata", resp_rdata, 32'h0);
    checkOutput("rst_wide_ready", wReqReady, 1'b1);
    reset = 1'b0;

    applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, -1, 0, -1);

    for (int i = 0; i < 4; i++) begin
      physMem[32'h101 + 32'(i)]  = 8'(8'h11 * (i + 1));
      modelMem[32'h101 + 32'(i)] = 8'(8'h11 * (i + 1));
    end
    applyStimulus(1'b0, 32'h0000_0101, 32'h0, 1'b0, -1, 0, -1);
    applyStimulus(1'b0, 32'h0000_0101, 32'h0, 1'b0, 1, 3, -1);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, -1, 0, -1);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      physMem[32'h1000 + 32'(i)]  = b;
      modelMem[32'h1000 + 32'(i)] = b;
    end
    for (int t = 0; t < 60; t++) begin
      logic [31:0] ad;
      ad = (t % 8 == 7) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4))
                        : 32'h1000 + 32'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), ad, $urandom, 1'b1, -1, 0, -1);
    end

    applyStimulus(1'b1, 32'h0000_1001, 32'hCAFE_F00D, 1'b0, -1, 0, 1);
    applyStimulus(1'b0, 32'h0000_1001, 32'h0, 1'b1, -1, 0, -1);

    // 32-bit bus instance: aligned single-beat load with a stray request mid-access
    @(negedge clock);
    wReqValid = 1'b1; wReqWrite = 1'b0; wReqAddr = 32'h0000_0200;
    #1;
    checkOutput("wide_accept_ready", wReqReady, 1'b1);
    checkOutput("wide_accept_stall", wStall, 1'b1);
    @(negedge clock);
    wReqValid = 1'b1; wReqWrite = 1'b1; wReqAddr = 32'h0000_0303; wBusRdata = 32'hA1B2_C3D4;
    #1;
    checkOutput("wide_beat_read", wBusRead, 1'b1);
    checkOutput("wide_beat_addr", 64'(wBusAddr), 64'h80);
    checkOutput("wide_beat_be", 64'(wBusBe), 64'hF);
    checkOutput("wide_beat_resp", wRespValid, 1'b0);
    @(negedge clock);
    wReqValid = 1'b0;
    #1;
    checkOutput("wide_done_resp", wRespValid, 1'b1);
    checkOutput("wide_done_rdata", wRespRdata, 32'hA1B2_C3D4);
    checkOutput("wide_done_bus", {wBusRead, wBusWrite}, 2'b00);
    @(negedge clock);
    #1;
    checkOutput("wide_after_ready", wReqReady, 1'b1);
    checkOutput("wide_after_resp", wRespValid, 1'b0);
    checkOutput("wide_after_bus", {wBusRead, wBusWrite, wBusWdata}, 34'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
